// File: rtl/qs_srt_decode.sv
// Sort-engine microsequencer decode stage: 16-bit inst_t -> registered ucode_t + PC_W target,
// with pop/load RAW bubble insertion, flush, invalid-opcode pulse and saturating stall counter.
package qs_srt_pkg;

  typedef logic [15:0] inst_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_JCC   = 4'h1;
  localparam logic [3:0] OP_PP    = 4'h2;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_MOV   = 4'h6;
  localparam logic [3:0] OP_ARITH = 4'h7;
  localparam logic [3:0] OP_CRET  = 4'hC;
  localparam logic [3:0] OP_CNTRL = 4'hF;

  localparam logic [2:0] BLINK = 3'd7;

  typedef struct packed {
    logic       is_jump;
    logic       is_call;
    logic       is_ret;
    logic       is_pop;
    logic       is_push;
    logic       is_load;
    logic       is_store;
    logic       is_done;
    logic       is_await;
    logic       invalid_inst;
    logic       dst_en;
    logic [2:0] dst;
    logic       dst_is_blink;
    logic       src0_en;
    logic [2:0] src0;
    logic       src0_is_zero;
    logic       src1_en;
    logic [2:0] src1;
    logic       has_imm;
    logic [7:0] imm;
    logic       has_special;
    logic [3:0] special;
    logic       flag_en;
    logic       inv_src1;
    logic       cin;
    logic [3:0] cc;
    logic [7:0] target;
  } ucode_t;

endpackage

module qs_srt_decode
  import qs_srt_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned HAZARD_EN = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_inst,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output ucode_t           out_ucode,
  output logic [PC_W-1:0]  out_target,
  input  logic             out_ready,
  output logic             invalid_o,
  output logic [CNT_W-1:0] stall_cnt
);

  ucode_t     dec;
  logic       b11;
  logic       raw;
  logic       hz;
  logic       accept;

  assign b11 = in_inst[11];

  always_comb begin
    dec = '0;
    unique case (in_inst[15:12])
      OP_NOP: dec = '0;
      OP_JCC: begin
        dec.is_jump = 1'b1;
        dec.cc      = in_inst[11:8];
        dec.target  = in_inst[7:0];
      end
      OP_PP: begin
        if (b11) begin
          dec.is_pop = 1'b1;
          dec.dst_en = 1'b1;
          dec.dst    = in_inst[10:8];
        end else begin
          dec.is_push = 1'b1;
          dec.src1_en = 1'b1;
          dec.src1    = in_inst[10:8];
        end
      end
      OP_MEM: begin
        dec.src1_en = 1'b1;
        dec.src1    = in_inst[2:0];
        if (b11) begin
          dec.is_store = 1'b1;
          dec.src0_en  = 1'b1;
          dec.src0     = in_inst[10:8];
        end else begin
          dec.is_load = 1'b1;
          dec.dst_en  = 1'b1;
          dec.dst     = in_inst[10:8];
        end
      end
      OP_MOV: begin
        dec.dst_en       = 1'b1;
        dec.dst          = in_inst[10:8];
        dec.src0_is_zero = 1'b1;
        if (b11) begin
          dec.has_imm = 1'b1;
          dec.imm     = in_inst[7:0];
        end else if (in_inst[7]) begin
          dec.has_special = 1'b1;
          dec.special     = in_inst[3:0];
        end else begin
          dec.src1_en = 1'b1;
          dec.src1    = in_inst[2:0];
        end
      end
      OP_ARITH: begin
        dec.dst_en  = in_inst[7];
        dec.dst     = in_inst[10:8];
        dec.src0_en = 1'b1;
        dec.src0    = in_inst[6:4];
        dec.flag_en = 1'b1;
        if (in_inst[3]) begin
          dec.has_imm = 1'b1;
          dec.imm     = {5'b0, in_inst[2:0]};
        end else begin
          dec.src1_en = 1'b1;
          dec.src1    = in_inst[2:0];
        end
        // Subtract is a + ~b + 1
        dec.inv_src1 = b11;
        dec.cin      = b11;
      end
      OP_CRET: begin
        if (b11) begin
          dec.is_ret  = 1'b1;
          dec.src0_en = 1'b1;
          dec.src0    = BLINK;
        end else begin
          dec.is_call      = 1'b1;
          dec.target       = in_inst[7:0];
          dec.dst_en       = 1'b1;
          dec.dst          = BLINK;
          dec.dst_is_blink = 1'b1;
        end
      end
      OP_CNTRL: begin
        dec.is_done  = b11;
        dec.is_await = ~b11;
      end
      default: dec.invalid_inst = 1'b1;
    endcase
  end

  // Consumer must not sit directly behind a pop/load that writes one of its sources.
  assign raw = out_valid && (out_ucode.is_pop || out_ucode.is_load) && out_ucode.dst_en &&
               in_valid &&
               ((dec.src0_en && (dec.src0 == out_ucode.dst)) ||
                (dec.src1_en && (dec.src1 == out_ucode.dst)));
  assign hz       = (HAZARD_EN != 0) ? raw : 1'b0;
  assign in_ready = (!out_valid || out_ready) && !hz && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ucode  <= '0;
      out_target <= '0;
      invalid_o  <= 1'b0;
    end else begin
      invalid_o <= accept && dec.invalid_inst;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_ucode  <= dec;
        out_target <= PC_W'(in_inst[7:0]);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (in_valid && hz && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_qs_srt_decode.sv
// Directed bench for qs_srt_decode: decode table, RAW bubbles, hold, flush, saturation, reset.
module tb_qs_srt_decode;
  import qs_srt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic iv_a, iv_n, iv_s;
  logic [15:0] in_inst;
  logic out_ready, flush;

  logic rdy_a, ov_a, inv_a;
  ucode_t u_a;
  logic [9:0] tg_a;
  logic [15:0] sc_a;

  logic rdy_n, ov_n, inv_n;
  ucode_t u_n;
  logic [9:0] tg_n;
  logic [15:0] sc_n;

  logic rdy_s, ov_s, inv_s;
  ucode_t u_s;
  logic [7:0] tg_s;
  logic [1:0] sc_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] inst;
    ucode_t      u;
    logic [9:0]  tgt;
    logic        inv;
  } vec_t;
  vec_t vq[$];

  qs_srt_decode #(.PC_W(10), .HAZARD_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_inst(in_inst), .in_ready(rdy_a),
    .flush(flush), .out_valid(ov_a), .out_ucode(u_a), .out_target(tg_a),
    .out_ready(out_ready), .invalid_o(inv_a), .stall_cnt(sc_a)
  );

  qs_srt_decode #(.PC_W(10), .HAZARD_EN(0), .CNT_W(16)) dut_nh (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_n), .in_inst(in_inst), .in_ready(rdy_n),
    .flush(flush), .out_valid(ov_n), .out_ucode(u_n), .out_target(tg_n),
    .out_ready(out_ready), .invalid_o(inv_n), .stall_cnt(sc_n)
  );

  qs_srt_decode #(.PC_W(8), .HAZARD_EN(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_inst(in_inst), .in_ready(rdy_s),
    .flush(flush), .out_valid(ov_s), .out_ucode(u_s), .out_target(tg_s),
    .out_ready(out_ready), .invalid_o(inv_s), .stall_cnt(sc_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] inst, input ucode_t u, input logic [9:0] tgt,
                     input logic inv);
    vec_t v;
    v.inst = inst;
    v.u    = u;
    v.tgt  = tgt;
    v.inv  = inv;
    vq.push_back(v);
  endtask

  ucode_t u;
  ucode_t u_addi;
  ucode_t u_inv;

  initial begin
    iv_a = 1'b0; iv_n = 1'b0; iv_s = 1'b0;
    in_inst = '0; out_ready = 1'b1; flush = 1'b0;

    // addi R4,R2,5
    u = '0; u.dst_en = 1; u.dst = 3'd4; u.src0_en = 1; u.src0 = 3'd2; u.flag_en = 1;
    u.has_imm = 1; u.imm = 8'd5;
    u_addi = u;
    add(16'h74AD, u, 10'h0AD, 1'b0);
    // sub R1,R2,R3
    u = '0; u.dst_en = 1; u.dst = 3'd1; u.src0_en = 1; u.src0 = 3'd2; u.src1_en = 1;
    u.src1 = 3'd3; u.flag_en = 1; u.inv_src1 = 1; u.cin = 1;
    add(16'h79A3, u, 10'h0A3, 1'b0);
    // arith without writeback, register source
    u = '0; u.dst = 3'd5; u.src0_en = 1; u.src0 = 3'd1; u.src1_en = 1; u.src1 = 3'd2;
    u.flag_en = 1;
    add(16'h7512, u, 10'h012, 1'b0);
    u = '0; u.is_pop = 1; u.dst_en = 1; u.dst = 3'd2;
    add(16'h2A00, u, 10'h000, 1'b0);
    u = '0; u.is_push = 1; u.src1_en = 1; u.src1 = 3'd5;
    add(16'h2500, u, 10'h000, 1'b0);
    u = '0; u.is_load = 1; u.dst_en = 1; u.dst = 3'd3; u.src1_en = 1; u.src1 = 3'd1;
    add(16'h4301, u, 10'h001, 1'b0);
    u = '0; u.is_store = 1; u.src0_en = 1; u.src0 = 3'd6; u.src1_en = 1; u.src1 = 3'd2;
    add(16'h4E02, u, 10'h002, 1'b0);
    u = '0; u.is_jump = 1; u.cc = 4'd2; u.target = 8'h35;
    add(16'h1235, u, 10'h035, 1'b0);
    u = '0; u.is_call = 1; u.target = 8'h80; u.dst_en = 1; u.dst = 3'd7; u.dst_is_blink = 1;
    add(16'hC080, u, 10'h080, 1'b0);
    u = '0; u.is_ret = 1; u.src0_en = 1; u.src0 = 3'd7;
    add(16'hC800, u, 10'h000, 1'b0);
    u = '0; u.dst_en = 1; u.dst = 3'd2; u.src0_is_zero = 1; u.has_imm = 1; u.imm = 8'h3C;
    add(16'h6A3C, u, 10'h03C, 1'b0);
    u = '0; u.dst_en = 1; u.dst = 3'd3; u.src0_is_zero = 1; u.has_special = 1;
    u.special = 4'd5;
    add(16'h6385, u, 10'h085, 1'b0);
    u = '0; u.dst_en = 1; u.dst = 3'd1; u.src0_is_zero = 1; u.src1_en = 1; u.src1 = 3'd4;
    add(16'h6104, u, 10'h004, 1'b0);
    u = '0; u.is_done = 1;
    add(16'hF800, u, 10'h000, 1'b0);
    u = '0; u.is_await = 1;
    add(16'hF000, u, 10'h000, 1'b0);
    u = '0;
    add(16'h0000, u, 10'h000, 1'b0);
    u = '0; u.invalid_inst = 1;
    u_inv = u;
    add(16'h3000, u, 10'h000, 1'b1);
    add(16'hD0FF, u, 10'h0FF, 1'b1);
    add(16'h8000, u, 10'h000, 1'b1);
    add(16'h5000, u, 10'h000, 1'b1);

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(ov_a), 64'd0);
    chk("rst_out_ucode", 64'(u_a), 64'd0);
    chk("rst_out_target", 64'(tg_a), 64'd0);
    chk("rst_invalid_o", 64'(inv_a), 64'd0);
    chk("rst_stall_cnt", 64'(sc_a), 64'd0);
    chk("rst_in_ready", 64'(rdy_a), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    foreach (vq[i]) begin
      in_inst = vq[i].inst;
      iv_a = 1'b1; iv_n = 1'b1; iv_s = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 64'(rdy_a), 64'd1);
      cyc();
      iv_a = 1'b0; iv_n = 1'b0; iv_s = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 64'(ov_a), 64'd1);
      chk($sformatf("vec%0d_ucode", i), 64'(u_a), 64'(vq[i].u));
      chk($sformatf("vec%0d_target", i), 64'(tg_a), 64'(vq[i].tgt));
      chk($sformatf("vec%0d_invalid_o", i), 64'(inv_a), 64'(vq[i].inv));
      cyc();
    end

    // pop R2 then sub R1,R2,R3: one bubble with hazard logic enabled
    in_inst = 16'h2A00; iv_a = 1'b1;
    @(negedge clk);
    chk("pop_in_ready", 64'(rdy_a), 64'd1);
    cyc();
    in_inst = 16'h79A3;
    @(negedge clk);
    chk("pop_out_valid", 64'(ov_a), 64'd1);
    chk("pop_is_pop", 64'(u_a.is_pop), 64'd1);
    chk("pop_sub_stalled", 64'(rdy_a), 64'd0);
    cyc();
    @(negedge clk);
    chk("pop_bubble", 64'(ov_a), 64'd0);
    chk("pop_bubble_ready", 64'(rdy_a), 64'd1);
    chk("pop_stall_cnt", 64'(sc_a), 64'd1);
    cyc();
    iv_a = 1'b0;
    @(negedge clk);
    chk("pop_sub_valid", 64'(ov_a), 64'd1);
    chk("pop_sub_inv_cin", 64'({u_a.inv_src1, u_a.cin, u_a.src1}), 64'h1B);
    cyc();

    // same pair with hazard logic disabled: no bubble
    in_inst = 16'h2A00; iv_n = 1'b1;
    cyc();
    in_inst = 16'h79A3;
    @(negedge clk);
    chk("nh_pop_valid", 64'(ov_n && u_n.is_pop), 64'd1);
    chk("nh_sub_ready", 64'(rdy_n), 64'd1);
    cyc();
    iv_n = 1'b0;
    @(negedge clk);
    chk("nh_sub_valid", 64'(ov_n), 64'd1);
    chk("nh_sub_inv", 64'(u_n.inv_src1), 64'd1);
    chk("nh_stall_cnt", 64'(sc_n), 64'd0);
    cyc();

    // ld R3,[R1] then sub (src1=R3) then addi: bubble before sub only
    in_inst = 16'h4301; iv_a = 1'b1;
    cyc();
    in_inst = 16'h79A3;
    @(negedge clk);
    chk("ld_out_is_load", 64'(ov_a && u_a.is_load), 64'd1);
    chk("ld_sub_stalled", 64'(rdy_a), 64'd0);
    cyc();
    @(negedge clk);
    chk("ld_bubble", 64'(ov_a), 64'd0);
    chk("ld_stall_cnt", 64'(sc_a), 64'd2);
    cyc();
    in_inst = 16'h74AD;
    @(negedge clk);
    chk("ld_sub_out", 64'(ov_a && u_a.inv_src1), 64'd1);
    chk("ld_addi_no_stall", 64'(rdy_a), 64'd1);
    cyc();
    iv_a = 1'b0;
    @(negedge clk);
    chk("ld_addi_valid", 64'(ov_a), 64'd1);
    chk("ld_addi_ucode", 64'(u_a), 64'(u_addi));
    chk("ld_stall_cnt_final", 64'(sc_a), 64'd2);
    cyc();

    // invalid opcode held under back-pressure; invalid_o is a single pulse
    in_inst = 16'h3000; iv_a = 1'b1;
    cyc();
    in_inst = 16'h74AD; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), 64'(ov_a), 64'd1);
      chk($sformatf("hold%0d_ucode", k), 64'(u_a), 64'(u_inv));
      chk($sformatf("hold%0d_invalid_o", k), 64'(inv_a), (k == 0) ? 64'd1 : 64'd0);
      chk($sformatf("hold%0d_in_ready", k), 64'(rdy_a), 64'd0);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_ready", 64'(rdy_a), 64'd1);
    cyc();
    iv_a = 1'b0;
    @(negedge clk);
    chk("hold_next_ucode", 64'(u_a), 64'(u_addi));
    chk("hold_next_invalid_o", 64'(inv_a), 64'd0);
    cyc();

    // flush kills the jump and blocks the waiting word for one cycle
    in_inst = 16'h1235; iv_a = 1'b1;
    cyc();
    in_inst = 16'h74AD; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(rdy_a), 64'd0);
    chk("flush_jump_valid", 64'(ov_a && u_a.is_jump), 64'd1);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(ov_a), 64'd0);
    chk("flush_ready_again", 64'(rdy_a), 64'd1);
    cyc();
    iv_a = 1'b0;
    @(negedge clk);
    chk("flush_replay_valid", 64'(ov_a), 64'd1);
    chk("flush_replay_ucode", 64'(u_a), 64'(u_addi));
    chk("flush_stall_cnt", 64'(sc_a), 64'd2);
    cyc();

    // 2-bit counter saturates while the hazard persists
    in_inst = 16'h2A00; iv_s = 1'b1;
    cyc();
    in_inst = 16'h79A3; out_ready = 1'b0;
    @(negedge clk);
    chk("sat_stalled", 64'(rdy_s), 64'd0);
    chk("sat_cnt0", 64'(sc_s), 64'd0);
    cyc(); cyc();
    @(negedge clk);
    chk("sat_cnt2", 64'(sc_s), 64'd2);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("sat_cnt_max", 64'(sc_s), 64'd3);
    iv_s = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    // asynchronous reset mid-stream
    in_inst = 16'h74AD; iv_a = 1'b1;
    cyc();
    iv_a = 1'b0;
    chk("mrst_pre_valid", 64'(ov_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(ov_a), 64'd0);
    chk("mrst_ucode", 64'(u_a), 64'd0);
    chk("mrst_stall_cnt", 64'(sc_a), 64'd0);
    chk("mrst_sat_cnt", 64'(sc_s), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    chk("mrst_dropped", 64'(ov_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
